// File: rtl/dlfloat_stream_if.sv
// Byte-in / word-out bundle for the DLFloat16 result stream receiver.
// The master drives the byte strobe and word_ready. The slave is the receiver and returns the head word.
interface dlfloat_stream_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              en;
   logic              align;
   logic [7:0]        byte_in;
   logic              word_valid;
   logic              word_ready;
   logic [15:0]       word_data;
   logic              word_sign;
   logic [5:0]        word_exp;
   logic [8:0]        word_mant;
   logic              word_is_zero;
   logic              word_is_special;
   logic              overflow;
   logic [CNT_W-1:0]  word_count;
   logic [LVL_W-1:0]  fifo_level;

   modport master (
      output en, align, byte_in, word_ready,
      input  word_valid, word_data, word_sign, word_exp, word_mant,
             word_is_zero, word_is_special, overflow, word_count, fifo_level
   );

   modport slave (
      input  en, align, byte_in, word_ready,
      output word_valid, word_data, word_sign, word_exp, word_mant,
             word_is_zero, word_is_special, overflow, word_count, fifo_level
   );
endinterface

// File: rtl/dlfloat_stream_rx.sv
// Rebuilds 16-bit DLFloat16 words from a low-byte-first byte stream.
// The words are queued in a small FIFO and the head word is decoded into its fields.
//
//   state   | meaning
//   --------+----------------------------------------------
//   PH_LOW  | next strobed byte is the low byte of a word
//   PH_HIGH | low byte held in low_q; next byte completes it
module dlfloat_stream_rx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst,
   dlfloat_stream_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   typedef enum logic {PH_LOW, PH_HIGH} phase_e;

   phase_e            phase_q, phase_d;
   logic [7:0]        low_q, low_d;
   logic [15:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              push, push_ok, pop, empty, full, drop;
   logic [15:0]       asm_word, head;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_LOW;
         low_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         low_q   <= low_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage needs no reset; an empty FIFO masks the head to zero.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem_q[wr_q] <= asm_word;
   end

   always_comb begin
      phase_d = phase_q;
      low_d   = low_q;
      push    = 1'b0;
      if (bus.en) begin
         if (bus.align || phase_q == PH_LOW) begin
            low_d   = bus.byte_in;
            phase_d = PH_HIGH;
         end else begin
            push    = 1'b1;
            phase_d = PH_LOW;
         end
      end
   end

   assign asm_word = {bus.byte_in, low_q};
   assign empty    = (level_q == '0);
   assign full     = (level_q == LVL_W'(DEPTH));
   assign pop      = !empty && bus.word_ready;
   // When the FIFO is full, a concurrent pop frees the slot the push needs.
   assign push_ok  = push && (!full || pop);
   assign drop     = push && full && !pop;

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      level_d = level_q;
      ovf_d   = ovf_q | drop;
      cnt_d   = cnt_q;
      if (push_ok) begin
         wr_d  = wr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push_ok) level_d = level_q - LVL_W'(1);
   end

   assign head                = empty ? 16'h0000 : mem_q[rd_q];
   assign bus.word_valid      = !empty;
   assign bus.word_data       = head;
   assign bus.word_sign       = head[15];
   assign bus.word_exp        = head[14:9];
   assign bus.word_mant       = head[8:0];
   assign bus.word_is_zero    = (head == 16'h0000);
   assign bus.word_is_special = (head == 16'hFFFF);
   assign bus.overflow        = ovf_q;
   assign bus.word_count      = cnt_q;
   assign bus.fifo_level      = level_q;
endmodule
